// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : N-channel switch debouncer. Each channel has its own
//                synchroniser, stability counter and 4-state FSM, and produces
//                a debounced level plus registered rise/fall ticks. An
//                aggregate any-event tick ORs all per-channel ticks together.
//  Revision    : 1.0  initial multi-channel release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i       in   1     system clock, rising edge
//    rst_i       in   1     asynchronous reset, active-high
//    en_i        in   1     1: FSMs/counters advance, 0: hold, ticks forced 0
//    sw_i        in   N_CH  raw asynchronous switch inputs
//    db_level_o  out  N_CH  debounced level per channel
//    db_tick_o   out  N_CH  one-cycle pulse on debounced 0->1
//    db_fall_o   out  N_CH  one-cycle pulse on debounced 1->0
//    db_any_o    out  1     OR of all db_tick_o and db_fall_o bits
// ============================================================================
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int INIT_LEVEL    = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [N_CH-1:0] sw_i,
    output logic [N_CH-1:0] db_level_o,
    output logic [N_CH-1:0] db_tick_o,
    output logic [N_CH-1:0] db_fall_o,
    output logic            db_any_o
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic             c_init_bit = (INIT_LEVEL != 0);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_t;

    localparam state_t c_rst_state = c_init_bit ? ST_ONE : ST_ZERO;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   w_sync;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        // Synchroniser runs regardless of en_i so the FSM always sees a fresh
        // sample when it is re-enabled.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync_q <= {SYNC_STAGES{c_init_bit}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i[c]};
            end
        end

        assign w_sync = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= c_rst_state;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // The counter only increments while below c_cnt_max, so it can never
        // wrap; reaching c_cnt_max with the input still stable commits the
        // new level and fires the tick in the same cycle.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (en_i) begin
                case (state_q)
                    ST_ZERO: begin
                        if (w_sync) begin
                            state_d = ST_WAIT1;
                            cnt_d   = '0;
                        end
                    end
                    ST_WAIT1: begin
                        if (!w_sync) begin
                            state_d = ST_ZERO;
                        end else if (cnt_q == c_cnt_max) begin
                            state_d = ST_ONE;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ST_ONE: begin
                        if (!w_sync) begin
                            state_d = ST_WAIT0;
                            cnt_d   = '0;
                        end
                    end
                    ST_WAIT0: begin
                        if (w_sync) begin
                            state_d = ST_ONE;
                        end else if (cnt_q == c_cnt_max) begin
                            state_d = ST_ZERO;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = c_rst_state;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // Level decoded straight from the state register: glitch-free.
        assign db_level_o[c] = (state_q == ST_ONE) || (state_q == ST_WAIT0);
        assign db_tick_o[c]  = rise_q;
        assign db_fall_o[c]  = fall_q;
    end : g_ch

    assign db_any_o = |{db_tick_o, db_fall_o};

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
module tb_debounce_multi;

    localparam int N_CH   = 4;
    localparam int STABLE = 20;
    localparam int SYNC   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: INIT_LEVEL = 0
    logic            rst, en;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] lvl, tick, fall;
    logic            any;

    // Instance B: INIT_LEVEL = 1
    logic            rst1;
    logic [N_CH-1:0] sw1;
    logic [N_CH-1:0] lvl1, tick1, fall1;
    logic            any1;

    int checks = 0;
    int errors = 0;

    debounce_multi #(.N_CH(N_CH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .INIT_LEVEL(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sw_i(sw),
        .db_level_o(lvl), .db_tick_o(tick), .db_fall_o(fall), .db_any_o(any)
    );

    debounce_multi #(.N_CH(N_CH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .INIT_LEVEL(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .en_i(en), .sw_i(sw1),
        .db_level_o(lvl1), .db_tick_o(tick1), .db_fall_o(fall1), .db_any_o(any1)
    );

    // ------------------------------------------------------------------
    // Reference model for instance A. The synchroniser is a pure delay of
    // SYNC samples; a channel flips once the synchronised input has
    // disagreed with the debounced level for STABLE+1 consecutive enabled
    // evaluations (any agreeing evaluation restarts the streak).
    // ------------------------------------------------------------------
    bit              m_hist[N_CH][$];
    bit [N_CH-1:0]   m_level, m_rise, m_fall;
    bit              m_any;
    int              m_run[N_CH];

    always @(posedge clk or posedge rst) begin
        bit s_m;
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                m_hist[c].delete();
                for (int k = 0; k < SYNC; k++) m_hist[c].push_back(1'b0);
                m_run[c] = 0;
            end
            m_level = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                s_m = m_hist[c].pop_front();
                m_hist[c].push_back(sw[c]);
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (en) begin
                    if (s_m != m_level[c]) begin
                        m_run[c]++;
                        if (m_run[c] == STABLE + 1) begin
                            m_level[c] = s_m;
                            if (s_m) m_rise[c] = 1'b1;
                            else     m_fall[c] = 1'b1;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
            m_any = |{m_rise, m_fall};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int n;
        rst = 1'b1; en = 1'b1; sw = '0;
        repeat (3) step();
        checks++;
        if ({lvl, tick, fall, any} !== 13'b0)
            begin errors++; $display("FAIL reset_state got %b want 0", {lvl, tick, fall, any}); end
        rst = 1'b0;
        step();
        // Park ch0 in WAIT1 with cnt=10, then reset between edges.
        sw[0] = 1'b1;
        repeat (13) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (lvl !== 4'b0000 || tick !== 4'b0000 || any !== 1'b0)
            begin errors++; $display("FAIL reset_midcount got lvl=%b tick=%b any=%b want 0", lvl, tick, any); end
        rst = 1'b0;
        step();                       // e0: first sample of sw[0]=1 after release
        n = 0;
        while (lvl[0] !== 1'b1 && n < 60) begin step(); n++; end
        checks++;
        if (n !== SYNC + STABLE)
            begin errors++; $display("FAIL reset_relatency got %0d want %0d", n, SYNC + STABLE); end
        // Asynchronous clear of a channel that is at level 1.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (lvl !== 4'b0000)
            begin errors++; $display("FAIL reset_async got %b want 0000", lvl); end
        step();
        rst = 1'b0; sw = '0;
        repeat (30) step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_clean_press();
        int n;
        sw[0] = 1'b1;
        step();
        n = 0;
        while (lvl[0] !== 1'b1 && n < 60) begin step(); n++; end
        checks++;
        if (n !== 22) begin errors++; $display("FAIL press_latency got %0d want 22", n); end
        checks++;
        if (tick !== 4'b0001 || fall !== 4'b0000 || any !== 1'b1 || lvl !== 4'b0001)
            begin errors++; $display("FAIL press_tick got tick=%b fall=%b any=%b lvl=%b want 0001/0000/1/0001", tick, fall, any, lvl); end
        step();
        checks++;
        if (tick !== 4'b0000 || any !== 1'b0 || lvl !== 4'b0001)
            begin errors++; $display("FAIL press_tick_width got tick=%b any=%b lvl=%b want 0000/0/0001", tick, any, lvl); end
        repeat (26) step();
        sw[0] = 1'b0;
        step();
        n = 0;
        while (lvl[0] !== 1'b0 && n < 60) begin step(); n++; end
        checks++;
        if (n !== 22 || fall !== 4'b0001 || tick !== 4'b0000 || any !== 1'b1)
            begin errors++; $display("FAIL release_fall got n=%0d fall=%b tick=%b any=%b want 22/0001/0000/1", n, fall, tick, any); end
        step();
        checks++;
        if (fall !== 4'b0000 || any !== 1'b0)
            begin errors++; $display("FAIL release_fall_width got fall=%b any=%b want 0000/0", fall, any); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bounce();
        int rises, falls, rise_at, fall_at;
        rises = 0; falls = 0; rise_at = -1; fall_at = -1;
        for (int k = 0; k < 5; k++) begin
            sw[1] = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (i == 19) sw[1] = 1'b0;
                step();
                checks++;
                if ({lvl, tick, fall, any} !== {m_level, m_rise, m_fall, m_any})
                    begin errors++; $display("FAIL bounce_model got %b want %b", {lvl, tick, fall, any}, {m_level, m_rise, m_fall, m_any}); end
                if (tick[1]) rises++;
            end
        end
        checks++;
        if (rises !== 0) begin errors++; $display("FAIL bounce_no_tick got %0d ticks want 0", rises); end
        sw[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            checks++;
            if ({lvl, tick, fall, any} !== {m_level, m_rise, m_fall, m_any})
                begin errors++; $display("FAIL bounce_model got %b want %b", {lvl, tick, fall, any}, {m_level, m_rise, m_fall, m_any}); end
            if (tick[1]) begin rises++; rise_at = i; end
        end
        checks++;
        if (rises !== 1 || rise_at !== 22)
            begin errors++; $display("FAIL bounce_rise got count=%0d at=%0d want 1 at 22", rises, rise_at); end
        sw[1] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (fall[1]) begin falls++; fall_at = i; end
        end
        checks++;
        if (falls !== 1 || fall_at !== 22 || lvl[1] !== 1'b0)
            begin errors++; $display("FAIL bounce_fall got count=%0d at=%0d lvl=%b want 1 at 22 lvl 0", falls, fall_at, lvl[1]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_coincident();
        int anys;
        anys = 0;
        sw[0] = 1'b1; sw[2] = 1'b1; sw[3] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (i == 9) sw[0] = 1'b0;
            checks++;
            if ({lvl, tick, fall, any} !== {m_level, m_rise, m_fall, m_any})
                begin errors++; $display("FAIL coinc_model got %b want %b", {lvl, tick, fall, any}, {m_level, m_rise, m_fall, m_any}); end
            if (any) begin
                anys++;
                checks++;
                if (tick !== 4'b1100)
                    begin errors++; $display("FAIL coinc_ticks got %b want 1100", tick); end
            end
        end
        checks++;
        if (anys !== 1 || lvl !== 4'b1100)
            begin errors++; $display("FAIL coinc_any got pulses=%0d lvl=%b want 1/1100", anys, lvl); end
        anys = 0;
        sw[2] = 1'b0; sw[3] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (any) begin
                anys++;
                checks++;
                if (fall !== 4'b1100 || tick !== 4'b0000)
                    begin errors++; $display("FAIL coinc_falls got fall=%b tick=%b want 1100/0000", fall, tick); end
            end
        end
        checks++;
        if (anys !== 1 || lvl !== 4'b0000)
            begin errors++; $display("FAIL coinc_fall_any got pulses=%0d lvl=%b want 1/0000", anys, lvl); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_enable();
        int n, busy;
        busy = 0;
        sw[1] = 1'b1;
        step();                       // e0
        n = 0;
        repeat (4) begin step(); n++; end
        en = 1'b0;
        repeat (10) begin
            step(); n++;
            if (tick !== 4'b0000 || fall !== 4'b0000 || any !== 1'b0 || lvl[1] !== 1'b0) busy++;
        end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL enable_hold got %0d active cycles want 0", busy); end
        en = 1'b1;
        while (lvl[1] !== 1'b1 && n < 80) begin step(); n++; end
        checks++;
        if (n !== 32 || tick !== 4'b0010)
            begin errors++; $display("FAIL enable_latency got n=%0d tick=%b want 32/0010", n, tick); end
        sw[1] = 1'b0;
        repeat (40) step();
        checks++;
        if (lvl !== 4'b0000) begin errors++; $display("FAIL enable_release got %b want 0000", lvl); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 24) == 0) sw[c] = ~sw[c];
            en = ($urandom_range(0, 15) != 0);
            step();
            checks++;
            if ({lvl, tick, fall, any} !== {m_level, m_rise, m_fall, m_any})
                begin errors++; $display("FAIL random_model cyc=%0d got %b want %b", i, {lvl, tick, fall, any}, {m_level, m_rise, m_fall, m_any}); end
        end
        en = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_init_level();
        int n;
        sw1 = 4'h0; rst1 = 1'b1;
        step(); step();
        checks++;
        if (lvl1 !== 4'hF || tick1 !== 4'h0 || fall1 !== 4'h0 || any1 !== 1'b0)
            begin errors++; $display("FAIL init_reset got lvl=%h tick=%h fall=%h any=%b want F/0/0/0", lvl1, tick1, fall1, any1); end
        rst1 = 1'b0;
        step();                       // e0: first sample of sw1=0
        n = 0;
        while (lvl1 !== 4'h0 && n < 60) begin
            step(); n++;
            if (tick1 !== 4'h0) begin errors++; checks++; $display("FAIL init_no_rise got %h want 0", tick1); end
        end
        checks++;
        if (n !== 22 || fall1 !== 4'hF || any1 !== 1'b1)
            begin errors++; $display("FAIL init_fall got n=%0d fall=%h any=%b want 22/F/1", n, fall1, any1); end
        step();
        checks++;
        if (fall1 !== 4'h0 || any1 !== 1'b0 || lvl1 !== 4'h0)
            begin errors++; $display("FAIL init_fall_width got fall=%h any=%b lvl=%h want 0/0/0", fall1, any1, lvl1); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sw = '0;
        rst1 = 1'b1; sw1 = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_coincident();
        test_enable();
        test_random();
        test_init_level();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
